// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch state type and default widths/reset PC
package fetch_sequencer_pkg;
  localparam int DEF_PC_W = 8;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_RESET_PC = 0;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction memory request/ack bus with master/slave views
interface fetch_sequencer_if #(
  parameter int PC_W = fetch_sequencer_pkg::DEF_PC_W,
  parameter int INSTR_W = fetch_sequencer_pkg::DEF_INSTR_W
);
  logic imem_req;
  logic [PC_W-1:0] imem_addr;
  logic imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// fetch_sequencer_pc_next_sel: next-PC priority mux (hold / redirect / pending / pc+1)
module fetch_sequencer_pc_next_sel import fetch_sequencer_pkg::*; #(
  parameter int PC_W = DEF_PC_W
) (
  input  fetch_state_e    state,
  input  logic            ack,
  input  logic            pend,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] pending,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc_next
);
  logic step;
  always_comb begin
    step = state != FETCH || ack;
    pc_next = !step ? pc : redirect_valid ? redirect_pc : state != FETCH ? pc : pend ? pending : pc + 1'b1;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and one-outstanding instruction fetch FSM
module fetch_sequencer import fetch_sequencer_pkg::*; #(
  parameter int PC_W = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  fetch_sequencer_if.master   imem,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     instr_pc,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                busy
);
  fetch_state_e state;
  logic [PC_W-1:0] pc, pending, pc_next;
  logic pend, drop;
  fetch_sequencer_pc_next_sel #(.PC_W(PC_W)) u_sel (
    .state(state), .ack(imem.imem_ack), .pend(pend), .redirect_valid(redirect_valid),
    .pc(pc), .pending(pending), .redirect_pc(redirect_pc), .pc_next(pc_next)
  );
  assign imem.imem_req = state == FETCH;
  assign imem.imem_addr = pc;
  assign busy = state != IDLE;
  assign drop = pend || redirect_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      pending <= '0;
      pend <= 1'b0;
      instr_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      pc <= pc_next;
      case (state)
        IDLE: state <= run ? FETCH : IDLE;
        FETCH:
          if (imem.imem_ack) begin
            pend <= 1'b0;
            state <= !drop ? HOLD : run ? FETCH : IDLE;
            if (!drop) begin
              instr_valid <= 1'b1;
              instr <= imem.imem_rdata;
              instr_pc <= pc;
            end
          end else if (redirect_valid) begin
            pending <= redirect_pc;
            pend <= 1'b1;
          end
        HOLD:
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            state <= run ? FETCH : IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic instr_ready = 1'b0;
  logic redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic instr_valid, busy;
  logic [31:0] instr;
  logic [7:0] instr_pc;
  logic run_w = 1'b0;
  logic instr_valid_w, busy_w;
  logic [31:0] instr_w;
  logic [7:0] instr_pc_w;
  int lat = 0;
  int wait_cnt = 0;
  int vectors = 0;
  int errors = 0;
  logic [7:0] exp_addr[$];
  logic [39:0] exp_data[$];
  logic [39:0] mon_e;
  fetch_sequencer_if bus();
  fetch_sequencer_if bus_w();
  always #5 clk = ~clk;
  function automatic logic [31:0] word(logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem(bus),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );
  fetch_sequencer #(.RESET_PC(8'hFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .imem(bus_w),
    .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w), .instr_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(8'h00), .busy(busy_w)
  );
  assign bus_w.imem_ack = bus_w.imem_req;
  assign bus_w.imem_rdata = word(bus_w.imem_addr);
  always @(posedge clk) begin
    #2;
    bus.imem_ack = bus.imem_req && wait_cnt == lat;
    wait_cnt = bus.imem_req && !bus.imem_ack ? wait_cnt + 1 : 0;
    bus.imem_rdata = word(bus.imem_addr);
  end
  always @(negedge clk)
    if (rst_n) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (exp_addr.size() == 0) chk("extra_fetch", 32'(exp_addr.size()), 32'd1);
        else chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_addr.pop_front()));
      end
      if (instr_valid && instr_ready) begin
        if (exp_data.size() == 0) chk("extra_instr", 32'(exp_data.size()), 32'd1);
        else begin
          mon_e = exp_data.pop_front();
          chk("instr_pc", 32'(instr_pc), 32'(mon_e[39:32]));
          chk("instr", instr, mon_e[31:0]);
        end
      end
    end
  initial begin
    logic [7:0] pat;
    logic [7:0] wpc[3];
    logic [31:0] wins[3];
    logic [7:0] wexp[3];
    int n;
    wexp = '{8'hFE, 8'hFF, 8'h00};
    instr_ready = 1'b1;
    nxt(2);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(8'(i));
      exp_data.push_back({8'(i), word(8'(i))});
    end
    run = 1'b1;
    pat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (i == 0) chk("run_to_req", 32'(bus.imem_req), 32'd1);
      pat[i] = instr_valid;
    end
    chk("valid_duty", 32'(pat), 32'hAA);
    run = 1'b0;
    nxt(2);
    chk("idle_busy", 32'(busy), 32'd0);
    exp_addr.push_back(8'h04);
    exp_addr.push_back(8'h40);
    lat = 3;
    run = 1'b1;
    nxt(2);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    nxt();
    redirect_valid = 1'b0;
    chk("wait_addr_a", 32'(bus.imem_addr), 32'h04);
    nxt();
    chk("wait_addr_b", 32'(bus.imem_addr), 32'h04);
    chk("wait_req", 32'(bus.imem_req), 32'd1);
    nxt();
    chk("redir_addr", 32'(bus.imem_addr), 32'h40);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, word(8'h40));
      chk("hold_pc", 32'(instr_pc), 32'h40);
      chk("hold_req", 32'(bus.imem_req), 32'd0);
    end
    exp_addr.push_back(8'h10);
    exp_data.push_back({8'h10, word(8'h10)});
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    nxt();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_addr", 32'(bus.imem_addr), 32'h10);
    chk("flush_req", 32'(bus.imem_req), 32'd1);
    lat = 2;
    instr_ready = 1'b1;
    run = 1'b0;
    nxt();
    chk("drop_req_a", 32'(bus.imem_req), 32'd1);
    nxt();
    chk("drop_req_b", 32'(bus.imem_req), 32'd1);
    chk("drop_addr", 32'(bus.imem_addr), 32'h10);
    nxt();
    chk("drop_deliver", 32'(instr_valid), 32'd1);
    nxt();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_idle_req", 32'(bus.imem_req), 32'd0);
    exp_addr.push_back(8'h00);
    exp_data.push_back({8'h00, word(8'h00)});
    lat = 5;
    run = 1'b1;
    nxt();
    chk("pre_rst_addr", 32'(bus.imem_addr), 32'h11);
    nxt();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
    nxt();
    lat = 0;
    rst_n = 1'b1;
    nxt();
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", 32'(bus.imem_addr), 32'd0);
    run = 1'b0;
    nxt(2);
    run_w = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      nxt();
      if (c == 0) chk("wrap_busy", 32'(busy_w), 32'd1);
      if (instr_valid_w) begin
        wpc[n] = instr_pc_w;
        wins[n] = instr_w;
        n++;
      end
    end
    run_w = 1'b0;
    chk("wrap_count", 32'(n), 32'd3);
    for (int i = 0; i < n; i++) begin
      chk("wrap_pc", 32'(wpc[i]), 32'(wexp[i]));
      chk("wrap_instr", wins[i], word(wexp[i]));
    end
    for (int c = 0; c < 20 && (exp_addr.size() != 0 || exp_data.size() != 0); c++) nxt();
    chk("addr_left", 32'(exp_addr.size()), 32'd0);
    chk("data_left", 32'(exp_data.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
